// File: rtl/mag_countdown_timer.sv
// Microwave cook-time countdown: BCD MM:SS keypad entry, 1 s decrement while mag_on, level done at 00:00.
// Optional "+30 s" key enabled by defining MAG_TIMER_ADD30_EN.
module mag_countdown_timer #(
   parameter int unsigned CLK_HZ = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       mag_on,
`ifdef MAG_TIMER_ADD30_EN
   input  logic       add30,
`endif
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       timer_done
);

   localparam int unsigned PW = $clog2(CLK_HZ);
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

   typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_RUN, S_PAUSED, S_DONE} state_t;

   state_t        state, state_nx;
   logic [3:0]    mt_nx, mo_nx, st_nx, so_nx;
   logic [PW-1:0] presc, presc_nx;
   logic          digit_ok;
   logic          time_zero;

   assign digit_ok  = digit_valid && (digit <= 4'd9);
   assign time_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);

   // State, time digits and prescaler; status flags follow the next state so they stay registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         min_tens   <= 4'd0;
         min_ones   <= 4'd0;
         sec_tens   <= 4'd0;
         sec_ones   <= 4'd0;
         presc      <= '0;
         running    <= 1'b0;
         timer_done <= 1'b0;
      end else begin
         state      <= state_nx;
         min_tens   <= mt_nx;
         min_ones   <= mo_nx;
         sec_tens   <= st_nx;
         sec_ones   <= so_nx;
         presc      <= presc_nx;
         running    <= (state_nx == S_RUN);
         timer_done <= (state_nx == S_DONE);
      end
   end

   always_comb begin
      state_nx = state;
      mt_nx    = min_tens;
      mo_nx    = min_ones;
      st_nx    = sec_tens;
      so_nx    = sec_ones;
      presc_nx = presc;
      if (clear) begin
         state_nx = S_IDLE;
         mt_nx    = 4'd0;
         mo_nx    = 4'd0;
         st_nx    = 4'd0;
         so_nx    = 4'd0;
         presc_nx = '0;
      end
`ifdef MAG_TIMER_ADD30_EN
      else if (add30) begin
         if (state == S_DONE) begin
            state_nx = S_ENTRY;
            mt_nx    = 4'd0;
            mo_nx    = 4'd0;
            st_nx    = 4'd3;
            so_nx    = 4'd0;
         end else begin
            if (state == S_IDLE) state_nx = S_ENTRY;
            // Seconds tens wraps by 3 with a BCD carry into minutes; 99 minutes cannot carry
            if (sec_tens < 4'd3) begin
               st_nx = sec_tens + 4'd3;
            end else if (!(min_tens == 4'd9 && min_ones == 4'd9)) begin
               st_nx = sec_tens - 4'd3;
               if (min_ones == 4'd9) begin
                  mo_nx = 4'd0;
                  mt_nx = min_tens + 4'd1;
               end else begin
                  mo_nx = min_ones + 4'd1;
               end
            end
         end
      end
`endif
      else begin
         case (state)
            S_IDLE, S_ENTRY: begin
               if (digit_ok) begin
                  state_nx = S_ENTRY;
                  mt_nx    = min_ones;
                  mo_nx    = sec_tens;
                  st_nx    = sec_ones;
                  so_nx    = digit;
               end else if (mag_on) begin
                  state_nx = time_zero ? S_DONE : S_RUN;
                  presc_nx = '0;
               end
            end
            S_RUN: begin
               if (!mag_on) begin
                  state_nx = S_PAUSED;
               end else if (presc == PRE_MAX) begin
                  presc_nx = '0;
                  // One-second BCD decrement with 59-second minute borrow
                  if (sec_ones != 4'd0) begin
                     so_nx = sec_ones - 4'd1;
                  end else begin
                     so_nx = 4'd9;
                     if (sec_tens != 4'd0) begin
                        st_nx = sec_tens - 4'd1;
                     end else begin
                        st_nx = 4'd5;
                        if (min_ones != 4'd0) begin
                           mo_nx = min_ones - 4'd1;
                        end else begin
                           mo_nx = 4'd9;
                           mt_nx = min_tens - 4'd1;
                        end
                     end
                  end
                  if ({mt_nx, mo_nx, st_nx, so_nx} == 16'h0000) state_nx = S_DONE;
               end else begin
                  presc_nx = presc + PW'(1);
               end
            end
            S_PAUSED: begin
               if (mag_on) state_nx = S_RUN;
            end
            S_DONE: begin
               if (digit_ok) begin
                  state_nx = S_ENTRY;
                  so_nx    = digit;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

endmodule
